// File: rtl/axis_join_pkg.sv
// axis_join_pkg: state encoding and round-robin selection shared by the join arbiter.
package axis_join_pkg;

  localparam int RR_MAX = 8;
  localparam int RR_W   = 3;

  typedef enum logic {
    JOIN_IDLE = 1'b0,
    JOIN_BUSY = 1'b1
  } join_state_e;

  // First set bit of req at or above ptr, wrapping around. Callers zero-extend
  // narrower request vectors, so wrapping at RR_MAX matches wrapping at S_COUNT.
  function automatic logic [RR_W-1:0] rr_select(input logic [RR_MAX-1:0] req,
                                                input logic [RR_W-1:0]   ptr);
    logic [RR_W-1:0] sel;
    logic [RR_W-1:0] idx;
    logic            found;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = ptr + RR_W'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// axis_skid_reg: 2-entry AXI-Stream skid buffer (output register + temp register).
// Input ready is fully registered, so there is no combinational path from
// m_ready to s_ready; one extra beat can land in the temp slot on a stall.
module axis_skid_reg #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] tmp_data_q, tmp_data_d;
  logic             out_valid_q, out_valid_d;
  logic             tmp_valid_q, tmp_valid_d;
  logic             ready_q, ready_d;

  // Steer an incoming beat into the output or temp slot; refill output from temp.
  always_comb begin
    out_data_d  = out_data_q;
    tmp_data_d  = tmp_data_q;
    out_valid_d = out_valid_q;
    tmp_valid_d = tmp_valid_q;
    ready_d     = m_ready | (!tmp_valid_q & (!out_valid_q | !s_valid));
    if (ready_q) begin
      if (m_ready || !out_valid_q) begin
        out_valid_d = s_valid;
        if (s_valid) out_data_d = s_data;
      end else begin
        tmp_valid_d = s_valid;
        if (s_valid) tmp_data_d = s_data;
      end
    end else if (m_ready) begin
      out_valid_d = tmp_valid_q;
      out_data_d  = tmp_data_q;
      tmp_valid_d = 1'b0;
    end
  end

  // Register both slots; reset empties the buffer and drops its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      tmp_data_q  <= '0;
      out_valid_q <= 1'b0;
      tmp_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      tmp_data_q  <= tmp_data_d;
      out_valid_q <= out_valid_d;
      tmp_valid_q <= tmp_valid_d;
      ready_q     <= ready_d;
    end
  end

  assign s_ready = ready_q;
  assign m_data  = out_data_q;
  assign m_valid = out_valid_q;

endmodule

// File: rtl/axis_join_arbiter.sv
// axis_join_arbiter: packet-atomic round-robin merge of S_COUNT AXI-Stream inputs.
// Optional macro AXIS_JOIN_TID_EN adds m_axis_tid carrying each beat's source index.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   JOIN_IDLE | no grant; one dead cycle used to pick the next requester
//   JOIN_BUSY | grant_q owns the output until its tlast beat is accepted
module axis_join_arbiter #(
  parameter int S_COUNT    = 3,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT-1:0]            ien,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          busy
`ifdef AXIS_JOIN_TID_EN
  ,
  output logic [$clog2(S_COUNT)-1:0]    m_axis_tid
`endif
);

  import axis_join_pkg::*;

`ifdef AXIS_JOIN_TID_EN
  localparam int TID_W  = $clog2(S_COUNT);
  localparam int SKID_W = DATA_WIDTH + 1 + TID_W;
`else
  localparam int SKID_W = DATA_WIDTH + 1;
`endif

  join_state_e         state_q, state_d;
  logic [RR_W-1:0]     grant_q, grant_d;
  logic [RR_W-1:0]     rr_q, rr_d;
  logic [S_COUNT-1:0]  req;
  logic                sel_valid, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                skid_s_valid, skid_s_ready;
  logic [SKID_W-1:0]   skid_s_data, skid_m_data;

  assign req  = s_axis_tvalid & ien;
  assign busy = (state_q == JOIN_BUSY);

  // Select the granted input's beat.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_q == RR_W'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Arbitrate in IDLE, then pass the granted input through until its tlast transfers.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    skid_s_valid  = 1'b0;
    s_axis_tready = '0;
    case (state_q)
      JOIN_IDLE: begin
        if (|req) begin
          grant_d = rr_select(RR_MAX'(req), rr_q);
          state_d = JOIN_BUSY;
        end
      end
      JOIN_BUSY: begin
        skid_s_valid = sel_valid;
        for (int i = 0; i < S_COUNT; i++) begin
          if (grant_q == RR_W'(i)) s_axis_tready[i] = skid_s_ready;
        end
        if (sel_valid && skid_s_ready && sel_last) begin
          state_d = JOIN_IDLE;
          rr_d    = (grant_q == RR_W'(S_COUNT - 1)) ? '0 : grant_q + RR_W'(1);
        end
      end
      default: state_d = JOIN_IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= JOIN_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

`ifdef AXIS_JOIN_TID_EN
  assign skid_s_data = {grant_q[TID_W-1:0], sel_last, sel_data};
  assign {m_axis_tid, m_axis_tlast, m_axis_tdata} = skid_m_data;
`else
  assign skid_s_data = {sel_last, sel_data};
  assign {m_axis_tlast, m_axis_tdata} = skid_m_data;
`endif

  axis_skid_reg #(
    .WIDTH(SKID_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .s_data (skid_s_data),
    .s_valid(skid_s_valid),
    .s_ready(skid_s_ready),
    .m_data (skid_m_data),
    .m_valid(m_axis_tvalid),
    .m_ready(m_axis_tready)
  );

endmodule

// File: tb/tb_axis_join_arbiter.sv
// tb_axis_join_arbiter: directed tests with a beat scoreboard and packet-order model.
module tb_axis_join_arbiter;

  localparam int S  = 3;
  localparam int DW = 64;
  localparam int TW = $clog2(S);

  logic            clk = 1'b0;
  logic            rst;
  logic [S-1:0]    ien;
  logic [S*DW-1:0] s_tdata;
  logic [S-1:0]    s_tlast, s_tvalid, s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tlast, m_tvalid, m_tready, busy;
`ifdef AXIS_JOIN_TID_EN
  logic [TW-1:0]   m_tid;
`endif

  always #5 clk = ~clk;

  axis_join_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .ien(ien),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .busy(busy)
`ifdef AXIS_JOIN_TID_EN
    , .m_axis_tid(m_tid)
`endif
  );

  typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] sd [S][64];
  logic          sl [S][64];
  int            wr [S];
  int            rd [S];

  beat_t         exp_q[$];
  int            out_order[$];
  int            exp_order[$];
  logic [DW-1:0] out_data[$];
  int            out_cyc[$];
  int            out_tid[$];
  int            first_sv, first_mv, busy_cnt, nready_busy, ready1_cnt;
  logic [S-1:0]  hs_n = '0;
  logic          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int            lit2 [6] = '{0, 1, 2, 0, 1, 2};
  int            lit3 [4] = '{0, 2, 0, 2};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_pkt(input int src, input int n, input logic [7:0] base);
    for (int b = 0; b < n; b++) begin
      sd[src][wr[src]] = (64'(src) << 56) | 64'(base + 8'(b));
      sl[src][wr[src]] = (b == n - 1);
      wr[src]++;
    end
  endtask

  task automatic clear_rec();
    out_order.delete(); out_data.delete(); out_cyc.delete(); out_tid.delete();
    first_sv = -1; first_mv = -1; busy_cnt = 0; nready_busy = 0; ready1_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < S; i++) rd[i] = wr[i];
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input logic [S-1:0] mask, input int limit, input logic use_pat,
                            input string name);
    int   n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < limit) begin
      @(posedge clk); #2;
      if (use_pat) m_tready = pat[n % 4];
      done = 1'b1;
      for (int i = 0; i < S; i++) if (mask[i] && rd[i] != wr[i]) done = 1'b0;
      if (exp_q.size() != 0 || m_tvalid || busy) done = 1'b0;
      n++;
    end
    m_tready = 1'b1;
    check({name, "_drained"}, done, 1);
  endtask

  // Packet-level round robin with every enabled input holding npk packets throughout.
  task automatic model_order(input logic [S-1:0] en, input int npk);
    int left [S];
    int ptr;
    int idx;
    ptr = 0;
    exp_order.delete();
    for (int i = 0; i < S; i++) left[i] = en[i] ? npk : 0;
    for (int n = 0; n < S * npk; n++) begin
      for (int k = 0; k < S; k++) begin
        idx = (ptr + k) % S;
        if (left[idx] > 0) begin
          exp_order.push_back(idx);
          left[idx]--;
          ptr = (idx + 1) % S;
          break;
        end
      end
    end
  endtask

  task automatic compare_order(input string name);
    check({name, "_order_len"}, out_order.size(), exp_order.size());
    for (int k = 0; k < exp_order.size(); k++)
      if (k < out_order.size()) check({name, "_order_src"}, out_order[k], exp_order[k]);
  endtask

  // Source driver: present queued beats, advance on each accepted handshake.
  initial begin
    s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    for (int i = 0; i < S; i++) begin wr[i] = 0; rd[i] = 0; end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < S; i++) begin
        if (hs_n[i] && rd[i] < wr[i]) rd[i]++;
        if (rd[i] < wr[i]) begin
          s_tvalid[i] = 1'b1;
          s_tlast[i]  = sl[i][rd[i]];
          s_tdata[i*DW +: DW] = sd[i][rd[i]];
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
        end
      end
    end
  end

  // Compare process: scoreboard, stall stability and buffer-occupancy rules each cycle.
  initial begin
    int    occ;
    logic  prev_stall, in_pkt;
    logic [DW-1:0] prev_d;
    logic  prev_l;
    int    src, cur_src;
    beat_t e;
    occ = 0; prev_stall = 0; in_pkt = 0; prev_d = '0; prev_l = 0; cur_src = 0;
    forever begin
      @(negedge clk);
      hs_n = s_tvalid & s_tready & {S{!rst}};
      if (rst) begin
        exp_q.delete();
        occ = 0; prev_stall = 0; in_pkt = 0;
      end else begin
        check("tready_onehot", $countones(s_tready) <= 1, 1);
        check("valid_iff_occupied", m_tvalid, occ > 0);
        if (prev_stall) begin
          check("stall_data", m_tdata, prev_d);
          check("stall_last", m_tlast, prev_l);
        end
        if (busy && occ == 0) check("ready_when_empty", |s_tready, 1);
        if (occ >= 2) check("notready_when_full", |s_tready, 0);
        if (m_tvalid && m_tready) begin
          src = int'(m_tdata[DW-1:DW-8]);
          check("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_data", m_tdata, e.d);
            check("out_last", m_tlast, e.l);
          end
          if (!in_pkt) begin
            out_order.push_back(src);
            cur_src = src;
          end else begin
            check("packet_atomic", src, cur_src);
          end
          in_pkt = !m_tlast;
          out_data.push_back(m_tdata);
          out_cyc.push_back(cyc);
`ifdef AXIS_JOIN_TID_EN
          check("tid_src", m_tid, src);
          out_tid.push_back(int'(m_tid));
`endif
          occ--;
        end
        for (int i = 0; i < S; i++) begin
          if (hs_n[i]) begin
            exp_q.push_back({s_tdata[i*DW +: DW], s_tlast[i]});
            occ++;
          end
        end
        if (busy) busy_cnt++;
        if (busy && s_tready == '0) nready_busy++;
        if (s_tready[1]) ready1_cnt++;
        if (first_sv < 0 && |s_tvalid) first_sv = cyc;
        if (first_mv < 0 && m_tvalid) first_mv = cyc;
        prev_stall = m_tvalid & !m_tready;
        prev_d = m_tdata;
        prev_l = m_tlast;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; ien = '1; m_tready = 1'b1;
    clear_rec();
    @(posedge clk); #2;
    @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Single 4-beat packet from input 0.
    clear_rec();
    load_pkt(0, 4, 8'hA0);
    wait_drain(3'b111, 100, 1'b0, "t1");
    check("t1_beats", out_data.size(), 4);
    for (int k = 0; k < out_data.size(); k++) check("t1_data", out_data[k], 64'hA0 + 64'(k));
    check("t1_latency", first_mv - first_sv, 2);
    check("t1_busy_cycles", busy_cnt, 4);
    if (out_cyc.size() == 4) check("t1_back_to_back", out_cyc[3] - out_cyc[0], 3);

    // All three inputs continuously offering 2-beat packets.
    do_reset(); clear_rec(); ien = 3'b111;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < S; i++) load_pkt(i, 2, 8'h20 + 8'(p * 16 + i * 4));
    wait_drain(3'b111, 300, 1'b0, "t2");
    model_order(3'b111, 2);
    for (int k = 0; k < 6; k++) check("model_pin_t2", exp_order[k], lit2[k]);
    compare_order("t2");

    // Input 1 disabled while all three request.
    do_reset(); clear_rec(); ien = 3'b101;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < S; i++) load_pkt(i, 2, 8'h40 + 8'(p * 16 + i * 4));
    wait_drain(3'b101, 300, 1'b0, "t3");
    check("t3_input1_never_ready", ready1_cnt, 0);
    model_order(3'b101, 2);
    for (int k = 0; k < 4; k++) check("model_pin_t3", exp_order[k], lit3[k]);
    compare_order("t3");

    // 6-beat packet under downstream ready pattern 1,0,0,1.
    do_reset(); clear_rec(); ien = 3'b111;
    load_pkt(0, 6, 8'h60);
    wait_drain(3'b111, 200, 1'b1, "t4");
    check("t4_beats", out_data.size(), 6);
    for (int k = 0; k < out_data.size(); k++) check("t4_data", out_data[k], 64'h60 + 64'(k));
    check("t4_backpressure_seen", nready_busy > 0, 1);

    // Reset in the middle of a 5-beat packet; pointer left at 2 beforehand.
    do_reset(); clear_rec(); ien = 3'b111;
    load_pkt(1, 1, 8'h10);
    wait_drain(3'b111, 100, 1'b0, "t5a");
    load_pkt(0, 5, 8'h50);
    n = 0;
    while (rd[0] < wr[0] - 3 && n < 50) begin @(posedge clk); #2; n++; end
    check("t5_two_beats_in", rd[0] >= wr[0] - 3, 1);
    load_pkt(2, 1, 8'h70);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    clear_rec();
    @(negedge clk);
    check("t5_post_rst_valid", m_tvalid, 0);
    check("t5_post_rst_busy", busy, 0);
    wait_drain(3'b111, 200, 1'b0, "t5");
    check("t5_order_len", out_order.size(), 2);
    if (out_order.size() == 2) begin
      check("t5_first_grant", out_order[0], 0);
      check("t5_second_grant", out_order[1], 2);
    end
    if (out_data.size() > 0) check("t5_first_beat", out_data[0], 64'h52);

    // Two single-beat packets from inputs 2 and 1.
    do_reset(); clear_rec(); ien = 3'b111;
    load_pkt(2, 1, 8'hC0);
    load_pkt(1, 1, 8'hB0);
    wait_drain(3'b111, 100, 1'b0, "t6");
    check("t6_order_len", out_order.size(), 2);
    if (out_order.size() == 2) begin
      check("t6_first", out_order[0], 1);
      check("t6_second", out_order[1], 2);
    end
    check("t6_busy_cycles", busy_cnt, 2);
`ifdef AXIS_JOIN_TID_EN
    if (out_tid.size() == 2) begin
      check("t6_tid0", out_tid[0], 1);
      check("t6_tid1", out_tid[1], 2);
    end
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_join_arbiter.md
Name: axis_join_arbiter

Overview:
- Reverse-direction counterpart of the datapath fork arbiter.
- Merges S_COUNT AXI4-Stream inputs onto one output stream.
- Arbitration is round-robin and packet-atomic: once an input is granted, it keeps the output until its tlast beat is accepted.
- Sits where per-channel result streams are collected back toward the DMA/host side.

Parameters:
- S_COUNT, 3, number of input streams (2..8).
- DATA_WIDTH, 64, tdata width in bits.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- ien  input  S_COUNT  per-input enable; a disabled input is never granted.
- s_axis_tdata  input  S_COUNT*DATA_WIDTH  packed input data; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tlast  input  S_COUNT  input end-of-packet.
- s_axis_tvalid  input  S_COUNT  input valid.
- s_axis_tready  output  S_COUNT  input ready.
- m_axis_tdata  output  DATA_WIDTH  merged data.
- m_axis_tlast  output  1  merged end-of-packet.
- m_axis_tvalid  output  1  merged valid.
- m_axis_tready  input  1  downstream ready.
- busy  output  1  high while a packet is granted (state BUSY).

Behaviour:
- Reset, on a clk edge with rst=1:
  - state=IDLE, rr pointer=0, skid buffer empty.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0, busy=0.
- Request vector: req = s_axis_tvalid & ien.
- IDLE:
  - All s_axis_tready=0.
  - If req!=0, select the first set bit at or above the rr pointer, wrapping at S_COUNT.
  - Register the selection as grant_idx and go to BUSY.
  - If req==0, stay in IDLE.
- BUSY:
  - s_axis_tready[grant_idx] = registered skid-ready flag; all other inputs' tready=0.
  - A beat transfers on s_axis_tvalid[g] & s_axis_tready[g] and enters the output skid.
  - When a transferred beat has tlast=1: go to IDLE and set rr pointer = (grant_idx+1) mod S_COUNT.
- Inter-packet gap: exactly one dead input cycle between packets, for arbitration.
- Output stage: 2-entry skid buffer (output register plus temp register).
  - Sustains 1 beat/cycle within a packet.
  - No combinational path from m_axis_tready to s_axis_tready.
  - Skid-ready next = m_axis_tready | (!temp_valid & (!m_axis_tvalid | !input_beat)).
- Latency: with s_axis_tvalid asserted in cycle 0 while IDLE and downstream ready, s_tready rises in cycle 1 and m_axis_tvalid rises in cycle 2.
- Output tdata/tlast are held stable while m_axis_tvalid=1 and m_axis_tready=0 (AXIS rule).
- ien is sampled only at arbitration. Deasserting ien mid-packet does not abort the packet; it completes.
- A granted input that drops tvalid mid-packet keeps the grant; there is no timeout.
- Single-beat packet (tlast on the first beat): BUSY lasts one cycle, then IDLE.
- Downstream backpressure with skid full: s_tready drops the next cycle; at most one extra beat is absorbed by the temp register.
- Reset mid-packet: the in-flight packet is truncated, and skid contents are discarded without emission.
- Simultaneous requests: round-robin order guarantees each enabled requester a grant within S_COUNT packets.

Optional Feature:
- Macro: AXIS_JOIN_TID_EN.
- Defined:
  - Adds output port m_axis_tid, width $clog2(S_COUNT), carrying the source index of each beat.
  - It travels through the skid alongside tdata and resets to 0.
- Undefined: the port and its storage are absent; behaviour is otherwise identical.

Decomposition:
- Shared package axis_join_pkg:
  - State encoding constants JOIN_IDLE=1'b0, JOIN_BUSY=1'b1.
  - Function rr_select(req, ptr) returning the grant index.
- Natural sub-module: axis_skid_reg (DATA_WIDTH+1+tid width wide), the 2-entry output buffer. Reusable by the fork side.

Test Plan:
- Single input 0 sends a 4-beat packet (0xA0..0xA3, tlast on the last beat), m_tready=1 -> m_axis emits A0..A3 in 4 consecutive cycles; first m_tvalid 2 cycles after s_tvalid; busy high for 4 cycles.
- All 3 inputs hold 2-beat packets continuously, ien=3'b111 -> packet order 0,1,2,0,1,2; no beats interleaved within a packet.
- ien=3'b101 with all inputs valid -> input 1 sees tready=0 forever; output alternates packets from 0 and 2.
- Downstream m_tready toggles 1,0,0,1 during a 6-beat packet -> no beat lost or duplicated; tdata is stable while stalled; s_tready lags by one cycle.
- rst asserted for 1 cycle mid-packet (after beat 2 of 5) -> next cycle m_tvalid=0, busy=0, rr pointer=0; next arbitration grants the lowest enabled requester.
- AXIS_JOIN_TID_EN defined, inputs 2 and 1 each send a 1-beat packet -> m_axis_tid shows 1 then 2 (rr from pointer 0), each with tlast=1.
